// File: rtl/main_mem_sram_responder.sv
// Word-addressed SRAM responder: captures one read or write, completes it after LATENCY cycles.
// Optional protocol checker enabled by defining MAIN_MEM_RESP_PROTO_CHECK_EN.
module main_mem_sram_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sram_rd,
  input  logic              sram_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sram_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_oe,
  output logic              err
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              capture;
  logic              mem_we;

  logic [DATA_W-1:0] mem [Depth];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sram_rd || sram_wr) begin
          capture = 1'b1;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StRelease;
      end
      StRelease: begin
        // Strobes are levels; require both low so a held request never retriggers.
        if (!sram_rd && !sram_wr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_rd_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (capture) begin
      // Read wins when both strobes are high.
      op_rd_q <= sram_rd;
      addr_q  <= addr;
      data_q  <= wr_data;
    end
  end

  assign sram_done  = (state_q == StDone);
  assign rd_data_oe = sram_done && op_rd_q;
  assign rd_data    = rd_data_oe ? mem[addr_q] : '0;
  assign mem_we     = sram_done && !op_rd_q;

  // Array is not reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

`ifdef MAIN_MEM_RESP_PROTO_CHECK_EN
  logic err_q;
  logic strobe_held;
  logic err_set;

  assign strobe_held = op_rd_q ? sram_rd : sram_wr;
  assign err_set     = (capture && sram_rd && sram_wr) ||
                       ((state_q == StBusy) && !strobe_held);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_main_mem_sram_responder.sv
// Directed bench: one LATENCY=4 and one LATENCY=1 responder driven by the same stimulus.
module tb_main_mem_sram_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sram_rd, sram_wr;
  logic [9:0]  addr;
  logic [31:0] wr_data;
  logic        done4, oe4, err4, done1, oe1, err1;
  logic [31:0] rdata4, rdata1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  main_mem_sram_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .sram_rd(sram_rd), .sram_wr(sram_wr), .addr(addr),
    .wr_data(wr_data), .sram_done(done4), .rd_data(rdata4), .rd_data_oe(oe4), .err(err4)
  );

  main_mem_sram_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sram_rd(sram_rd), .sram_wr(sram_wr), .addr(addr),
    .wr_data(wr_data), .sram_done(done1), .rd_data(rdata1), .rd_data_oe(oe1), .err(err1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one request from a negedge, holds strobes 8 cycles, then releases for one cycle.
  // Capture is at the next posedge, so done is seen on negedge LATENCY+1.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    int t4 = 0, t1 = 0, n4 = 0, n1 = 0, bad = 0;
    logic [31:0] r4 = 32'hFFFF_FFFF, r1 = 32'hFFFF_FFFF;
    logic o4 = 1'bx, o1 = 1'bx;
    logic [31:0] exp_bus;
    exp_bus = rd ? exp_rd : 32'h0;
    sram_rd = rd;
    sram_wr = wr;
    addr    = a;
    wr_data = d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done4) begin
        n4++;
        if (t4 == 0) t4 = k;
        r4 = rdata4;
        o4 = oe4;
      end else if (oe4 || rdata4 != 32'h0) begin
        bad++;
      end
      if (done1) begin
        n1++;
        if (t1 == 0) t1 = k;
        r1 = rdata1;
        o1 = oe1;
      end else if (oe1 || rdata1 != 32'h0) begin
        bad++;
      end
      // Perturb inputs while the op is in flight; it must not notice.
      if (k == 2) begin
        addr    = ~a;
        wr_data = ~d;
      end
    end
    check_eq({tag, "/lat4"}, t4, 5);
    check_eq({tag, "/lat1"}, t1, 2);
    check_eq({tag, "/pulses4"}, n4, 1);
    check_eq({tag, "/pulses1"}, n1, 1);
    check_eq({tag, "/rdata4"}, r4, exp_bus);
    check_eq({tag, "/oe4"}, o4, rd);
    check_eq({tag, "/rdata1"}, r1, exp_bus);
    check_eq({tag, "/oe1"}, o1, rd);
    check_eq({tag, "/idle_bus"}, bad, 0);
    sram_rd = 1'b0;
    sram_wr = 1'b0;
    @(negedge clk);
  endtask

  logic exp_err;

  initial begin
`ifdef MAIN_MEM_RESP_PROTO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n = 1'b0;
    sram_rd = 1'b0;
    sram_wr = 1'b0;
    addr    = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst/done", done4, 0);
    check_eq("rst/oe", oe4, 0);
    check_eq("rst/rdata", rdata4, 0);
    check_eq("rst/err", err4, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("wr012", 1'b0, 1'b1, 10'h012, 32'hDEAD_BEEF, 32'h0);
    do_op("rd012", 1'b1, 1'b0, 10'h012, 32'h0, 32'hDEAD_BEEF);
    do_op("wr001", 1'b0, 1'b1, 10'h001, 32'h1111_1111, 32'h0);
    do_op("wr000", 1'b0, 1'b1, 10'h000, 32'hA5A5_0000, 32'h0);
    do_op("wr3ff", 1'b0, 1'b1, 10'h3FF, 32'h0000_5A5A, 32'h0);
    do_op("rd000", 1'b1, 1'b0, 10'h000, 32'h0, 32'hA5A5_0000);
    do_op("rd3ff", 1'b1, 1'b0, 10'h3FF, 32'h0, 32'h0000_5A5A);

    // Abort a write to 0x001 with reset; a read held through reset is captured afterwards.
    sram_wr = 1'b1;
    addr    = 10'h001;
    wr_data = 32'h5;
    @(negedge clk);
    check_eq("abort/done_k1", done4, 0);
    @(negedge clk);
    check_eq("abort/done_k2", done4, 0);
    reset_n = 1'b0;
    #1;
    check_eq("abort/done_rst", done4, 0);
    check_eq("abort/done1_rst", done1, 0);
    check_eq("abort/oe_rst", oe4, 0);
    sram_wr = 1'b0;
    sram_rd = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort/done_hold", done4, 0);
    reset_n = 1'b1;
    do_op("rd001", 1'b1, 1'b0, 10'h001, 32'h0, 32'h1111_1111);

    check_eq("err/before", err4, 0);
    do_op("rdwr012", 1'b1, 1'b1, 10'h012, 32'h0BAD_F00D, 32'hDEAD_BEEF);
    check_eq("err/both4", err4, exp_err);
    check_eq("err/both1", err1, exp_err);
    do_op("rd012b", 1'b1, 1'b0, 10'h012, 32'h0, 32'hDEAD_BEEF);
    check_eq("err/sticky", err4, exp_err);
    reset_n = 1'b0;
    #1;
    check_eq("err/cleared", err4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_mem_sram_responder.md
MAIN_MEM_SRAM_RESPONDER -- requirements
Module: main_mem_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word address width; array depth is 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32: data word width.
REQ-003 SHALL have parameter LATENCY, default 4: cycles from request capture to sram_done; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sram_rd, input, 1 bit: read request level, held by the initiator until sram_done.
REQ-007 SHALL have port sram_wr, input, 1 bit: write request level, held by the initiator until sram_done.
REQ-008 SHALL have port addr, input, ADDR_W bits: word address, sampled at capture.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write data, sampled at capture.
REQ-010 SHALL have port sram_done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rd_data, output, DATA_W bits: read data, valid only while rd_data_oe=1.
REQ-012 SHALL have port rd_data_oe, output, 1 bit: tri-state drive enable for the shared read bus.
REQ-013 SHALL have port err, output, 1 bit: sticky protocol-error flag (see Configuration).

Function
REQ-014 SHALL implement four states: IDLE, BUSY, DONE, RELEASE.
REQ-015 IDLE: when sram_rd or sram_wr is 1, SHALL capture op, addr and wr_data and go to BUSY; counter loads LATENCY-1.
REQ-016 If sram_rd and sram_wr are both 1 in IDLE, SHALL capture as a read (read wins).
REQ-017 BUSY: counter decrements each cycle; at 0 SHALL go to DONE; a request with LATENCY=1 spends one BUSY cycle.
REQ-018 Capture-to-done SHALL take exactly LATENCY cycles: sram_done is high in cycle N+LATENCY for capture edge N.
REQ-019 DONE: sram_done=1 for exactly one cycle; write ops SHALL update the array at the DONE edge with the captured data.
REQ-020 DONE, read op: rd_data SHALL equal array[captured addr] and rd_data_oe=1, both only during the DONE cycle; rd_data=0 otherwise.
REQ-021 A read of an address written by the immediately preceding op SHALL return the new data.
REQ-022 RELEASE: SHALL wait until sram_rd=0 and sram_wr=0, then go to IDLE; held strobes never retrigger.
REQ-023 RELEASE with both strobes already 0 SHALL reach IDLE after one cycle; the next capture is possible one cycle later.
REQ-024 Input changes to addr, wr_data or strobes during BUSY/DONE SHALL NOT affect the in-flight op.
REQ-025 Array contents SHALL be uninitialized (X) until written.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, counter 0, sram_done=0, rd_data_oe=0, rd_data=0, err=0.
REQ-027 Reset mid-operation SHALL abort the op with no array write and no sram_done pulse; array contents are preserved.
REQ-028 After reset_n rises, a strobe still held SHALL be captured as a new request at the next clock edge.

Configuration
REQ-029 Macro MAIN_MEM_RESP_PROTO_CHECK_EN SHALL gate the checker.
REQ-030 Defined: err sets and stays set until reset when (a) sram_rd and sram_wr are both 1 at capture, or (b) an in-flight op's strobe drops before sram_done.
REQ-031 Undefined: err tied to 0, no checker logic; all other behaviour identical.

Verification
REQ-032 LATENCY=4: write addr 0x012 data 0xDEADBEEF, hold sram_wr -> sram_done 4 cycles after capture, one cycle wide, rd_data_oe=0.
REQ-033 Then read 0x012 -> sram_done 4 cycles after capture with rd_data=0xDEADBEEF and rd_data_oe=1 in that cycle only.
REQ-034 Hold sram_rd 3 cycles past sram_done -> no second sram_done; after release, capture resumes one cycle after IDLE.
REQ-035 reset_n low 2 cycles after a write capture to 0x001 (data 0x5) -> no sram_done; a later read of 0x001 returns its prior value.
REQ-036 With MAIN_MEM_RESP_PROTO_CHECK_EN: sram_rd=sram_wr=1 at capture -> read performed, err=1 sticky until reset; without the macro, err stays 0.
REQ-037 LATENCY=1: back-to-back reads of 0x000 and 0x3FF -> each sram_done exactly one cycle after its capture.
